// File: rtl/softmax_stream_tx_16.sv
// Element buffer plus AXI4-Stream transmitter: collects a vector of elements, then
// emits them two per beat (even element in the low half) with registered outputs.
module softmax_stream_tx_16 #(
    parameter int unsigned          data_size    = 16,
    parameter logic [data_size-1:0] pad_value    = 16'h8000,
    parameter int unsigned          buffer_depth = 256
) (
    input  logic                     axi_clock_i,
    input  logic                     axi_reset_i,
    input  logic                     start_i,
    input  logic [7:0]               vector_length_i,
    input  logic                     wr_valid_i,
    input  logic [data_size-1:0]     wr_data_i,
    output logic                     wr_ready_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     m_axis_valid_o,
    output logic [2*data_size-1:0]   m_axis_data_o,
    output logic                     m_axis_last_o,
    input  logic                     m_axis_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [data_size-1:0]   mem_r [buffer_depth];
    logic [7:0]             len_r;
    logic [7:0]             wr_idx_r;
    logic [7:0]             beat_r;
    logic                   wr_ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   valid_r;
    logic                   last_r;
    logic [2*data_size-1:0] data_r;

    logic                   wr_fire_s;
    logic                   start_ok_s;
    logic                   last_wr_s;
    logic                   out_fire_s;
    logic                   load_beat_s;
    logic                   final_beat_s;
    logic [7:0]             num_beats_s;
    logic [7:0]             lo_idx_s;
    logic [7:0]             hi_idx_s;
    logic [data_size-1:0]   lo_elem_s;
    logic [data_size-1:0]   hi_elem_s;

    // Handshake qualifiers and buffer read of the next beat's element pair
    always_comb begin
        wr_fire_s    = wr_valid_i & wr_ready_r;
        start_ok_s   = start_i & (vector_length_i != 8'd0);
        last_wr_s    = (wr_idx_r == (len_r - 8'd1));
        out_fire_s   = valid_r & m_axis_ready_i;
        num_beats_s  = {1'b0, len_r[7:1]} + {7'd0, len_r[0]};
        // A new beat may enter the output register when it is empty or draining now
        load_beat_s  = (~valid_r | m_axis_ready_i) & (beat_r < num_beats_s);
        final_beat_s = (beat_r == (num_beats_s - 8'd1));
        lo_idx_s     = {beat_r[6:0], 1'b0};
        hi_idx_s     = {beat_r[6:0], 1'b1};
        lo_elem_s    = mem_r[lo_idx_s];
        if (final_beat_s && len_r[0]) begin
            hi_elem_s = pad_value;
        end else begin
            hi_elem_s = mem_r[hi_idx_s];
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (wr_fire_s && last_wr_s) begin
                    next_state_s = SEND;
                end else begin
                    next_state_s = LOAD;
                end
            end
            SEND: begin
                if (out_fire_s && last_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SEND;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
        if (axi_reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Counters, status flags and the stream output register
    always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
        if (axi_reset_i) begin
            len_r      <= 8'd0;
            wr_idx_r   <= 8'd0;
            beat_r     <= 8'd0;
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            data_r     <= '0;
        end else begin
            wr_ready_r <= (next_state_s == LOAD);
            busy_r     <= (next_state_s != IDLE);
            done_r     <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        len_r    <= vector_length_i;
                        wr_idx_r <= 8'd0;
                        beat_r   <= 8'd0;
                    end
                end
                LOAD: begin
                    if (wr_fire_s) begin
                        wr_idx_r <= wr_idx_r + 8'd1;
                    end
                end
                SEND: begin
                    if (load_beat_s) begin
                        data_r  <= {hi_elem_s, lo_elem_s};
                        valid_r <= 1'b1;
                        last_r  <= final_beat_s;
                        beat_r  <= beat_r + 8'd1;
                    end else if (out_fire_s) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Element storage; contents survive reset since every vector rewrites what it reads
    always_ff @(posedge axi_clock_i) begin
        if (wr_fire_s) begin
            mem_r[wr_idx_r] <= wr_data_i;
        end
    end

    assign wr_ready_o     = wr_ready_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign m_axis_valid_o = valid_r;
    assign m_axis_data_o  = data_r;
    assign m_axis_last_o  = last_r;

endmodule

// File: tb/tb_softmax_stream_tx_16.sv
// Bench for softmax_stream_tx_16: directed and random vectors compared against a
// beat list built from the written elements.
module tb_softmax_stream_tx_16;

    localparam logic [15:0] PAD = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  vlen;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] elems[$];

    softmax_stream_tx_16 dut (
        .axi_clock_i     (clk),
        .axi_reset_i     (rst),
        .start_i         (start),
        .vector_length_i (vlen),
        .wr_valid_i      (wr_valid),
        .wr_data_i       (wr_data),
        .wr_ready_o      (wr_ready),
        .busy_o          (busy),
        .done_o          (done),
        .m_axis_valid_o  (m_valid),
        .m_axis_data_o   (m_data),
        .m_axis_last_o   (m_last),
        .m_axis_ready_i  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        elems.delete();
        for (int i = 0; i < n; i++) begin
            elems.push_back(16'($urandom));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, m_valid, 1'b0);
        check({tag, "_last"}, m_last, 1'b0);
        check({tag, "_data"}, m_data, 32'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_wr_ready"}, wr_ready, 1'b0);
    endtask

    // rmode: 0 ready held high, 1 random ready, 2 ready low for the first 5 cycles
    task automatic run_vector(input int len, input int rmode, input bit noise, input int abort_after);
        logic [31:0] beats[$];
        logic [15:0] hi;
        int nb;
        int w;
        int k;
        int cyc;
        int stall;
        nb = (len + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            hi = (2 * b + 1 < len) ? elems[2 * b + 1] : PAD;
            beats.push_back({hi, elems[2 * b]});
        end
        ready = 1'b0;
        start = 1'b1;
        vlen  = len[7:0];
        tick();
        start = 1'b0;
        vlen  = 8'd0;
        check("busy_after_start", busy, 1'b1);

        w = 0;
        cyc = 0;
        while (w < len && cyc < 5000) begin
            check("wr_ready_load", wr_ready, 1'b1);
            check("valid_in_load", m_valid, 1'b0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = elems[w];
            if (wr_valid) w++;
            tick();
            cyc++;
        end
        check("write_phase_complete", 64'(w), 64'(len));
        wr_valid = noise;
        wr_data  = 16'hdead;
        check("wr_ready_after_load", wr_ready, 1'b0);
        check("valid_one_cycle_after_load", m_valid, 1'b0);
        if (noise) begin
            start = 1'b1;
            vlen  = 8'd5;
        end
        tick();

        k = 0;
        stall = 0;
        cyc = 0;
        while (k < nb && cyc < 5000) begin
            check("valid", m_valid, 1'b1);
            check("data", m_data, beats[k]);
            check("last", m_last, (k == nb - 1));
            check("busy_send", busy, 1'b1);
            check("done_send", done, 1'b0);
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (stall >= 5);
            endcase
            stall++;
            if (ready) k++;
            tick();
            cyc++;
            if (abort_after != 0 && k == abort_after) begin
                #1 rst = 1'b1;
                #1;
                check_all_zero("reset_mid_send");
                @(posedge clk);
                #1 rst = 1'b0;
                ready    = 1'b0;
                start    = 1'b0;
                wr_valid = 1'b0;
                return;
            end
        end
        check("send_phase_complete", 64'(k), 64'(nb));
        ready = 1'b0;
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b1);
        check("valid_after_last", m_valid, 1'b0);
        check("last_after_last", m_last, 1'b0);
        if (noise) begin
            start = 1'b1;
            vlen  = 8'd3;
        end
        tick();
        start    = 1'b0;
        vlen     = 8'd0;
        wr_valid = 1'b0;
        check("done_cleared", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("wr_ready_idle", wr_ready, 1'b0);
        check("valid_idle", m_valid, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        vlen     = 8'd0;
        wr_valid = 1'b0;
        wr_data  = 16'd0;
        ready    = 1'b0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        elems = {16'd1, 16'd2, 16'd3, 16'd4};
        run_vector(4, 0, 1'b0, 0);

        elems = {16'h0010, 16'h0020, 16'h0030};
        run_vector(3, 0, 1'b0, 0);

        elems = {16'd1, 16'd2, 16'd3, 16'd4};
        run_vector(4, 2, 1'b0, 0);

        start = 1'b1;
        vlen  = 8'd0;
        tick();
        start = 1'b0;
        check("zero_len_busy", busy, 1'b0);
        check("zero_len_wr_ready", wr_ready, 1'b0);
        tick();
        check("zero_len_busy_later", busy, 1'b0);

        fill_random(6);
        run_vector(6, 1, 1'b1, 0);

        fill_random(255);
        run_vector(255, 1, 1'b1, 0);

        fill_random(8);
        run_vector(8, 0, 1'b0, 2);
        check("after_abort_idle", busy, 1'b0);
        fill_random(2);
        run_vector(2, 0, 1'b0, 0);

        for (int v = 0; v < 5; v++) begin
            int len;
            len = $urandom_range(1, 20);
            fill_random(len);
            run_vector(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        elems = {16'h0abc};
        run_vector(1, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/softmax_stream_tx_16.md
SOFTMAX_STREAM_TX_16 -- requirements
Module: softmax_stream_tx_16

Interface
REQ-001 SHALL have parameter data_size, default 16, element width in bits.
REQ-002 SHALL have parameter pad_value, default 16'h8000, filler for the upper half of an odd-length final beat.
REQ-003 SHALL have parameter buffer_depth, default 256, element buffer entries.
REQ-004 SHALL have ports: axi_clock_i  in  1  single clock, rising edge; axi_reset_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: start_i  in  1  begin a vector; vector_length_i  in  8  element count, sampled on accepted start.
REQ-006 SHALL have ports: wr_valid_i  in  1; wr_data_i  in  data_size  element; wr_ready_o  out  1  element write handshake.
REQ-007 SHALL have ports: busy_o  out  1  not IDLE; done_o  out  1  one-cycle pulse, vector fully sent.
REQ-008 SHALL have ports: m_axis_valid_o  out  1; m_axis_data_o  out  2*data_size; m_axis_last_o  out  1; m_axis_ready_i  in  1  AXI4-Stream master.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, SEND, DONE.
REQ-010 IDLE->LOAD SHALL occur on start_i=1 with vector_length_i!=0; length latched to len.
REQ-011 start_i with vector_length_i=0, or start_i outside IDLE, SHALL be ignored.
REQ-012 wr_ready_o SHALL be 1 only in LOAD; each wr_valid_i&wr_ready_o cycle stores wr_data_i at write index 0,1,2,...
REQ-013 LOAD->SEND SHALL occur in the cycle after the len-th write handshake; wr_ready_o SHALL be 0 from that cycle.
REQ-014 SEND SHALL emit ceil(len/2) beats; beat k SHALL carry element 2k in [data_size-1:0] and element 2k+1 in [2*data_size-1:data_size].
REQ-015 Odd len: final beat upper half SHALL be pad_value.
REQ-016 m_axis_valid_o SHALL first rise exactly 2 cycles after the len-th write handshake.
REQ-017 Once valid is 1, data/last/valid SHALL hold stable until m_axis_valid_o&m_axis_ready_i.
REQ-018 With m_axis_ready_i held 1, beats SHALL issue back-to-back, one per cycle, no bubbles.
REQ-019 m_axis_last_o SHALL be 1 only on the final beat of a vector, coincident with valid.
REQ-020 After the final beat handshake: SEND->DONE, done_o=1 for that one DONE cycle, then DONE->IDLE.
REQ-021 m_axis_valid_o SHALL never depend combinationally on m_axis_ready_i.
REQ-022 busy_o SHALL be 1 in LOAD, SEND, DONE.
REQ-023 wr_valid_i while wr_ready_o=0 SHALL have no effect.
REQ-024 Write index and beat counter SHALL be 8-bit, reset to 0 on each accepted start; no wrap possible since len<=255<buffer_depth.
REQ-025 start_i in DONE cycle SHALL be ignored; a new vector needs a start in IDLE.

Reset
REQ-026 axi_reset_i=1 SHALL immediately force IDLE, clear counters, and drive wr_ready_o, busy_o, done_o, m_axis_valid_o, m_axis_last_o to 0 and m_axis_data_o to 0.
REQ-027 Reset mid-LOAD or mid-SEND SHALL abandon the vector with no further beats; buffer contents need not be cleared.
REQ-028 After deassertion the block SHALL accept start_i in the first clock edge.

Verification
REQ-029 len=4, writes 1,2,3,4, ready=1 -> beats 32'h0002_0001, 32'h0004_0003 (last=1) on consecutive cycles, done_o one pulse.
REQ-030 len=3, writes 16'h0010,16'h0020,16'h0030 -> beats 32'h0020_0010, 32'h8000_0030 with last=1.
REQ-031 len=4, ready low 5 cycles at first valid -> 32'h0002_0001 held stable 5 cycles, then both beats, last on second only.
REQ-032 start with len=0, then start during SEND -> both ignored; busy_o stays 0 then unaffected; beat count unchanged.
REQ-033 len=255, random ready -> 128 beats, last only on beat 128, upper half pad_value, order matches writes.
REQ-034 Assert axi_reset_i after 2nd beat of len=8 -> all outputs 0 same cycle; next len=2 vector sends correctly.
